// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: two-channel round-robin sector read scheduler for a shared SD read engine
module sd_read_arbiter #(
  parameter bit LOOP         = 1'b0,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic        sd_clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        rd_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        rd_owner,
  output logic        rd_owner_valid,
  input  logic        ch0_en,
  input  logic [31:0] ch0_start_section,
  input  logic [31:0] ch0_end_section,
  input  logic        ch0_fifo_almost_full,
  output logic        ch0_active,
  output logic        ch0_done,
  input  logic        ch1_en,
  input  logic [31:0] ch1_start_section,
  input  logic [31:0] ch1_end_section,
  input  logic        ch1_fifo_almost_full,
  output logic        ch1_active,
  output logic        ch1_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  state_t state, state_nxt;
  logic [TW-1:0] cnt;
  logic [1:0] en, en_q, aff, active, done, elig, own;
  logic [1:0][31:0] start, stop, ptr;
  logic busy_q, rr_last, gnt, tmo, comp;
  assign en = {ch1_en, ch0_en};
  assign aff = {ch1_fifo_almost_full, ch0_fifo_almost_full};
  assign start = {ch1_start_section, ch0_start_section};
  assign stop = {ch1_end_section, ch0_end_section};
  assign {ch1_active, ch0_active} = active;
  assign {ch1_done, ch0_done} = done;
  assign elig = active & ~aff & {2{sd_init_done}};
  assign gnt = &elig ? ~rr_last : elig[1];
  assign tmo = cnt == TW'(BUSY_TIMEOUT - 1);
  assign comp = state == WAIT_DONE && busy_q && !rd_busy;
  assign rd_start_en = state == ISSUE;
  assign rd_owner_valid = state != IDLE;
  assign own = {rd_owner_valid & rd_owner, rd_owner_valid & ~rd_owner};
  always_ff @(posedge sd_clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE      ? (|elig ? ISSUE : IDLE) :
                state == ISSUE     ? WAIT_BUSY :
                state == WAIT_BUSY ? (rd_busy ? WAIT_DONE : tmo ? IDLE : WAIT_BUSY) :
                                     (comp ? IDLE : WAIT_DONE);
  end
  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      cnt <= '0;
      en_q <= '0;
      busy_q <= 1'b0;
      rr_last <= 1'b1;
      rd_sec_addr <= '0;
      rd_owner <= 1'b0;
      active <= '0;
      done <= '0;
      ptr <= '0;
    end else begin
      busy_q <= rd_busy;
      cnt <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
      if (state == IDLE && |elig) begin
        rd_sec_addr <= ptr[gnt];
        rd_owner <= gnt;
        rr_last <= gnt;
      end
      for (int i = 0; i < 2; i++) begin
        done[i] <= 1'b0;
        if (!own[i]) en_q[i] <= en[i];
        if (comp && own[i]) begin
          if (!en[i] || !active[i]) active[i] <= 1'b0;
          else if (ptr[i] != stop[i]) ptr[i] <= ptr[i] + 32'd1;
          else if (LOOP) ptr[i] <= start[i];
          else begin
            done[i] <= 1'b1;
            active[i] <= 1'b0;
          end
        end else if (!own[i] && en[i] && !en_q[i]) begin
          ptr[i] <= start[i];
          active[i] <= !(start[i] > stop[i]);
          done[i] <= start[i] > stop[i];
        end else if (!own[i] && !en[i] && en_q[i]) begin
          active[i] <= 1'b0;
        end
      end
    end
  end
endmodule
